// File: rtl/st7735s_spi_sequencer.sv
// ST7735S panel init sequencer: hardware reset, ROM-driven command/data bytes over SPI mode 0.
// Optional pixel streaming after init is enabled by defining ST7735S_PIXEL_STREAM_EN.
module st7735s_spi_sequencer #(
  parameter int CLK_DIV      = 2,
  parameter int RST_CYCLES   = 1_000,
  parameter int DELAY_CYCLES = 12_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [8:0] command,
  input  logic       finished,
  output logic       advance,
  output logic       resend,
  input  logic [7:0] pixel_data,
  input  logic       pixel_valid,
  output logic       pixel_ready,
  output logic       sck,
  output logic       mosi,
  output logic       cs_n,
  output logic       dc,
  output logic       lcd_rst_n,
  output logic       busy,
  output logic       init_done
);

  typedef enum logic [3:0] {
    IDLE, HWRST, HWWAIT, REWIND, SETTLE, FETCH, SHIFT, POSTDLY, ADV, STREAM, DONE
  } state_e;

  localparam int CNT_MAX = (DELAY_CYCLES > RST_CYCLES) ? DELAY_CYCLES : RST_CYCLES;
  localparam int CW      = (CNT_MAX < 3) ? 2 : $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] DLY_LAST    = CW'(DELAY_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(2);
  localparam logic [7:0]    DIV_LAST    = 8'(CLK_DIV - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sr_q, sr_d;
  logic [8:0]    word_q, word_d;
  logic          sck_q, sck_d;
  logic          mosi_q, mosi_d;
  logic          cs_n_q, cs_n_d;
  logic          dc_q, dc_d;
  logic          shift_q, shift_d;

  logic shifting, half_end, byte_end;

  assign shifting = (state_q == SHIFT) || ((state_q == STREAM) && shift_q);
  assign half_end = (div_q == DIV_LAST);
  assign byte_end = half_end && sck_q && (bit_q == 3'd7);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      word_q  <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      dc_q    <= 1'b0;
      shift_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      word_q  <= word_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      dc_q    <= dc_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    word_d  = word_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    dc_d    = dc_q;
    shift_d = shift_q;

    // Shared bit engine: low half with data set up, then high half; mosi moves as sck falls.
    if (shifting) begin
      if (half_end) begin
        div_d = '0;
        if (!sck_q) begin
          sck_d = 1'b1;
        end else begin
          sck_d = 1'b0;
          if (bit_q == 3'd7) begin
            bit_d  = '0;
            mosi_d = 1'b0;
          end else begin
            bit_d  = bit_q + 3'd1;
            sr_d   = {sr_q[6:0], 1'b0};
            mosi_d = sr_q[6];
          end
        end
      end else begin
        div_d = div_q + 8'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = HWRST;
          cnt_d   = '0;
        end
      end
      HWRST: begin
        if (cnt_q == RST_LAST) begin
          state_d = HWWAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HWWAIT: begin
        if (cnt_q == DLY_LAST) begin
          state_d = REWIND;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REWIND: begin
        state_d = SETTLE;
        cnt_d   = '0;
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = FETCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FETCH: begin
        if (finished) begin
`ifdef ST7735S_PIXEL_STREAM_EN
          state_d = STREAM;
          dc_d    = 1'b1;
          cs_n_d  = 1'b0;
          shift_d = 1'b0;
`else
          state_d = DONE;
`endif
        end else begin
          // dc and cs_n change on the same edge, so dc never moves while selected
          state_d = SHIFT;
          word_d  = command;
          dc_d    = command[8];
          sr_d    = command[7:0];
          mosi_d  = command[7];
          sck_d   = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          cs_n_d  = 1'b0;
        end
      end
      SHIFT: begin
        if (byte_end) begin
          cs_n_d  = 1'b1;
          cnt_d   = '0;
          state_d = ((word_q == 9'h001) || (word_q == 9'h011)) ? POSTDLY : ADV;
        end
      end
      POSTDLY: begin
        if (cnt_q == DLY_LAST) begin
          state_d = ADV;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ADV: begin
        state_d = SETTLE;
        cnt_d   = '0;
      end
`ifdef ST7735S_PIXEL_STREAM_EN
      STREAM: begin
        if (!shift_q && pixel_valid) begin
          shift_d = 1'b1;
          sr_d    = pixel_data;
          mosi_d  = pixel_data[7];
          sck_d   = 1'b0;
          div_d   = '0;
          bit_d   = '0;
        end else if (shift_q && byte_end) begin
          shift_d = 1'b0;
        end
      end
`endif
      DONE: ;
      default: state_d = IDLE;
    endcase
  end

  assign sck       = sck_q;
  assign mosi      = mosi_q;
  assign cs_n      = cs_n_q;
  assign dc        = dc_q;
  assign lcd_rst_n = (state_q != HWRST);
  assign advance   = (state_q == ADV);
  assign resend    = (state_q == REWIND);
  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign init_done = (state_q == STREAM) || (state_q == DONE);

`ifdef ST7735S_PIXEL_STREAM_EN
  assign pixel_ready = (state_q == STREAM) && !shift_q;
`else
  assign pixel_ready = 1'b0;
  logic unused_pix;
  assign unused_pix = ^{pixel_data, pixel_valid};
`endif

endmodule

// File: tb/tb_st7735s_spi_sequencer.sv
// Directed bench for st7735s_spi_sequencer with a small registered ROM model.
module tb_st7735s_spi_sequencer;
  logic       clk = 1'b0;
  logic       rst_n, start, finished, advance, resend;
  logic [8:0] command;
  logic [7:0] pixel_data;
  logic       pixel_valid, pixel_ready;
  logic       sck, mosi, cs_n, dc, lcd_rst_n, busy, init_done;

  int errors = 0;
  int checks = 0;

  logic [8:0] rom [0:7];
  logic [2:0] idx;
  logic [8:0] cmd_q;

  always #5 clk = ~clk;

  st7735s_spi_sequencer #(.CLK_DIV(2), .RST_CYCLES(10), .DELAY_CYCLES(50)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .command(command), .finished(finished),
    .advance(advance), .resend(resend), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .sck(sck), .mosi(mosi), .cs_n(cs_n), .dc(dc),
    .lcd_rst_n(lcd_rst_n), .busy(busy), .init_done(init_done)
  );

  always @(posedge clk) begin
    if (!rst_n) begin
      idx   <= '0;
      cmd_q <= '0;
    end else begin
      if (resend)       idx <= '0;
      else if (advance) idx <= idx + 3'd1;
      cmd_q <= rom[idx];
    end
  end
  assign command  = cmd_q;
  assign finished = (cmd_q == 9'h000);

  // Captures one framed init byte starting at the negedge where cs_n first reads low.
  task automatic capture_byte(output logic [7:0] b, output int cyc, output logic dcv,
                              output logic dc_stable);
    logic prev;
    b = '0; cyc = 0; prev = 1'b0; dcv = dc; dc_stable = 1'b1;
    while (cs_n === 1'b0 && cyc < 200) begin
      if (sck && !prev) b = {b[6:0], mosi};
      if (dc !== dcv) dc_stable = 1'b0;
      prev = sck;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; pixel_valid = 1'b0; pixel_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({sck, mosi, cs_n, dc, lcd_rst_n, advance, resend, pixel_ready, busy, init_done} !== 10'b0010100000) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=%b",
        {sck, mosi, cs_n, dc, lcd_rst_n, advance, resend, pixel_ready, busy, init_done}, 10'b0010100000);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_hwreset;
    int n, m, r;
    logic busy_bad, rst_bad;
    busy_bad = 1'b0; rst_bad = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (lcd_rst_n === 1'b0 && n < 100) begin
      if (busy !== 1'b1) busy_bad = 1'b1;
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 10) begin errors++; $display("FAIL hwrst_low_cycles got=%0d want=10", n); end
    m = 0;
    while (resend !== 1'b1 && m < 200) begin
      if (lcd_rst_n !== 1'b1) rst_bad = 1'b1;
      if (busy !== 1'b1) busy_bad = 1'b1;
      start = (m == 20);
      m++;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (m != 50) begin errors++; $display("FAIL hwwait_cycles got=%0d want=50", m); end
    checks++;
    if (rst_bad) begin errors++; $display("FAIL start_while_busy lcd_rst_n dropped got=1 want=0"); end
    r = 0;
    while (resend === 1'b1 && r < 5) begin
      if (busy !== 1'b1) busy_bad = 1'b1;
      r++;
      @(negedge clk);
    end
    checks++;
    if (r != 1) begin errors++; $display("FAIL resend_width got=%0d want=1", r); end
    checks++;
    if (busy_bad) begin errors++; $display("FAIL busy_during_reset got=0 want=1"); end
  endtask

  task automatic test_init_bytes;
    logic [8:0] exp_w [0:3];
    logic [7:0] b;
    logic       dcv, dcs;
    int         cyc, n, gap;
    exp_w[0] = 9'h001; exp_w[1] = 9'h011; exp_w[2] = 9'h13C; exp_w[3] = 9'h02C;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (cs_n !== 1'b0 && n < 20) begin n++; @(negedge clk); end
      checks++;
      if (n >= 20) begin errors++; $display("FAIL byte%0d_cs_timeout got=%0d want<20", k, n); end
      capture_byte(b, cyc, dcv, dcs);
      checks++;
      if (b !== exp_w[k][7:0]) begin errors++; $display("FAIL byte%0d_mosi got=%h want=%h", k, b, exp_w[k][7:0]); end
      checks++;
      if (cyc != 32) begin errors++; $display("FAIL byte%0d_length got=%0d want=32", k, cyc); end
      checks++;
      if (dcv !== exp_w[k][8] || !dcs) begin
        errors++; $display("FAIL byte%0d_dc got=%b stable=%b want=%b", k, dcv, dcs, exp_w[k][8]);
      end
      gap = 0;
      while (advance !== 1'b1 && gap < 100) begin
        if (cs_n !== 1'b1) gap = 1000;
        gap++;
        @(negedge clk);
      end
      checks++;
      if (k < 2) begin
        if (gap != 50) begin errors++; $display("FAIL byte%0d_postdelay got=%0d want=50", k, gap); end
      end else if (gap > 2) begin
        errors++; $display("FAIL byte%0d_advance_gap got=%0d want<=2", k, gap);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_finish;
    int n;
    n = 0;
    while (init_done !== 1'b1 && n < 20) begin n++; @(negedge clk); end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL init_done_timeout got=%0d want<20", n); end
`ifdef ST7735S_PIXEL_STREAM_EN
    begin
      logic [7:0] b;
      logic prev, bad;
      checks++;
      if ({busy, cs_n, dc, pixel_ready} !== 4'b1011) begin
        errors++; $display("FAIL stream_entry got=%b want=1011", {busy, cs_n, dc, pixel_ready});
      end
      pixel_data = 8'hA5; pixel_valid = 1'b1;
      @(negedge clk);
      pixel_valid = 1'b0;
      b = '0; prev = 1'b0; bad = 1'b0;
      for (int i = 0; i < 32; i++) begin
        if (sck && !prev) b = {b[6:0], mosi};
        if (cs_n !== 1'b0 || dc !== 1'b1 || pixel_ready !== 1'b0) bad = 1'b1;
        prev = sck;
        @(negedge clk);
      end
      checks++;
      if (b !== 8'hA5) begin errors++; $display("FAIL pixel_mosi got=%h want=a5", b); end
      checks++;
      if (bad) begin errors++; $display("FAIL pixel_framing got=bad want=cs_n0_dc1_ready0"); end
      bad = 1'b0;
      repeat (5) begin
        if (sck !== 1'b0 || cs_n !== 1'b0 || pixel_ready !== 1'b1) bad = 1'b1;
        @(negedge clk);
      end
      checks++;
      if (bad) begin errors++; $display("FAIL stream_idle got=bad want=sck0_cs_n0_ready1"); end
    end
`else
    checks++;
    if ({busy, cs_n, pixel_ready} !== 3'b010) begin
      errors++; $display("FAIL done_outputs got=%b want=010", {busy, cs_n, pixel_ready});
    end
    begin
      logic bad;
      bad = 1'b0;
      pixel_data = 8'hA5; pixel_valid = 1'b1;
      repeat (10) begin
        if (sck !== 1'b0 || cs_n !== 1'b1 || pixel_ready !== 1'b0 || init_done !== 1'b1) bad = 1'b1;
        @(negedge clk);
      end
      pixel_valid = 1'b0;
      checks++;
      if (bad) begin errors++; $display("FAIL done_ignores_pixels got=bad want=idle_bus"); end
    end
`endif
  endtask

  task automatic test_midbyte_reset;
    logic [7:0] b;
    logic       dcv, dcs, prev;
    int n, rises, cyc;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (cs_n !== 1'b0 && n < 200) begin n++; @(negedge clk); end
    rises = 0; prev = 1'b0; n = 0;
    while (rises < 4 && n < 100) begin
      if (sck && !prev) rises++;
      prev = sck;
      n++;
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({sck, mosi, cs_n, dc, lcd_rst_n, advance, resend, pixel_ready, busy, init_done} !== 10'b0010100000) begin
      errors++;
      $display("FAIL midbyte_reset got=%b want=%b",
        {sck, mosi, cs_n, dc, lcd_rst_n, advance, resend, pixel_ready, busy, init_done}, 10'b0010100000);
    end
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (lcd_rst_n === 1'b0 && n < 100) begin n++; @(negedge clk); end
    checks++;
    if (n != 10) begin errors++; $display("FAIL rerun_hwrst got=%0d want=10", n); end
    n = 0;
    while (cs_n !== 1'b0 && n < 200) begin n++; @(negedge clk); end
    capture_byte(b, cyc, dcv, dcs);
    checks++;
    if (b !== 8'h01 || cyc != 32) begin
      errors++; $display("FAIL rerun_first_byte got=%h/%0d want=01/32", b, cyc);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rom[i] = 9'h000;
    rom[0] = 9'h001; rom[1] = 9'h011; rom[2] = 9'h13C; rom[3] = 9'h02C;
    rst_n = 1'b0; start = 1'b0; pixel_valid = 1'b0; pixel_data = '0;
    test_reset();
    test_hwreset();
    test_init_bytes();
    test_finish();
    test_midbyte_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
